main_memory_copy_master: RTL
============================

Name: main_memory_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words within the on-chip main memory (single-port RAM slave, 14-bit word address, 32-bit data, byteenable, read latency 1).
- Sits between a control agent (CPU-side register block or test logic) and the memory slave port.
- Performs a forward word-by-word copy: read source, capture, write destination.
- Pulses done when the copy finishes; flags illegal ranges without touching memory.

Parameters:
ADDR_W, 14, word address width of the memory port and of src/dst/len.
DATA_W, 32, data width; byteenable width is DATA_W/8.
DEPTH, 10024, number of valid words; the highest legal word address is DEPTH-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
src_addr  in  ADDR_W  first source word address.
dst_addr  in  ADDR_W  first destination word address.
len  in  ADDR_W  number of words to copy.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse at completion, including the error and zero-length cases.
error  out  1  range error; held until the next accepted start.
checksum  out  DATA_W  modulo-2^32 sum of the copied words (see Optional Feature).
m_address  out  ADDR_W  memory word address.
m_byteenable  out  DATA_W/8  always all-ones while chipselect is high, otherwise 0.
m_chipselect  out  1  memory select.
m_write  out  1  write strobe; qualified by chipselect.
m_writedata  out  DATA_W  write data.
m_readdata  in  DATA_W  read data, valid the cycle after a read cycle.
m_clken  out  1  memory clock enable; constant 1 after reset.

Behaviour:
- Reset (asynchronous, reset_n=0): state returns to IDLE.
- Outputs during reset: busy=0, done=0, error=0, checksum=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0, m_byteenable=0.
- m_clken is 1 in all states.
- States: IDLE, CHECK, RD, LAT, WR, FIN.
- IDLE: start=1 latches src, dst and len, clears error and checksum, and moves to CHECK.
- CHECK (1 cycle, no bus activity):
  - If src+len > DEPTH or dst+len > DEPTH, using ADDR_W+1-bit sums: set error=1 and go to FIN.
  - Else if len==0: go to FIN.
  - Else: go to RD.
- RD: chipselect=1, write=0, address=src+idx.
- LAT: chipselect=0; capture m_readdata into the data register.
- WR: chipselect=1, write=1, address=dst+idx, writedata=data register.
  - idx increments.
  - If idx+1==len go to FIN, else go to RD.
- FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Timing: 3 cycles per word. For a valid len=N>0, done asserts 3N+2 cycles after the start cycle (CHECK at +1, first RD at +2).
- busy is high from the CHECK cycle through the FIN cycle inclusive.
- start while not in IDLE is ignored; no queuing.
- Overlapping ranges: the copy is strictly ascending. When dst>src and the ranges overlap, already-written words are re-read, so the source pattern propagates forward. This is the defined behaviour.
- Addresses never wrap: the range check guarantees src+idx and dst+idx stay ≤ DEPTH-1.
- Reset mid-copy aborts immediately. Words already written stay in memory and no done pulse is produced.
- The bus is idle (chipselect=0) in IDLE, CHECK, LAT and FIN.

Optional Feature:
- Macro COPY_CHECKSUM_EN.
- Defined: in each LAT cycle checksum <= checksum + m_readdata, modulo 2^32. The value is valid when done pulses and held until the next accepted start.
- Undefined: checksum is tied to 0 and no adder is built. All other behaviour is identical.

Test Plan:
- Zero-length: preload 0..7 with 0x11..0x88; start src=0 dst=100 len=0 → done at start+2, error=0, no chipselect ever high.
- Basic copy: preload words 0..3 = 0xA0000000..0xA0000003; start src=0 dst=200 len=4 → done at start+14; mem[200..203] equal the source; checksum=0x80000006 with COPY_CHECKSUM_EN, 0 without.
- Range error: start src=10000 dst=0 len=30 → error=1, done at start+2, no memory access; error clears on the next valid start.
- Last-word boundary: start src=0 dst=10023 len=1 → legal; mem[10023] = mem[0]. Same with len=2 → error.
- Overlap plus ignored start: mem[0..3]=1,2,3,4; start src=0 dst=1 len=3 → mem[0..3]=1,1,1,1. A second start pulsed mid-copy is ignored.
- Reset mid-copy: start len=8, assert reset_n=0 on cycle 7 → all outputs 0 immediately. Only the first two destination words are written; a subsequent start works normally.

Source files
------------

// File: rtl/main_memory_copy_master.sv
// Avalon-MM block copy master: 3 cycles per word, done at start+3N+2; no backpressure (fixed latency-1 slave).
// Optional COPY_CHECKSUM_EN adds a modulo-2^32 sum of every word read.
module main_memory_copy_master #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 10024
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [ADDR_W-1:0]   len,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [DATA_W-1:0]   checksum,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W/8-1:0] m_byteenable,
   output logic                m_chipselect,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   input  logic [DATA_W-1:0]   m_readdata,
   output logic                m_clken
);

   typedef enum logic [2:0] {IDLE, CHECK, RD, LAT, WR, FIN} state_t;

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] src_r;
   logic [ADDR_W-1:0] dst_r;
   logic [ADDR_W-1:0] len_r;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_nxt;
   logic [ADDR_W:0]   src_end;
   logic [ADDR_W:0]   dst_end;
   logic              range_bad;

   // Sums are one bit wider so a range ending exactly at DEPTH is not mistaken for a wrap.
   assign src_end   = {1'b0, src_r} + {1'b0, len_r};
   assign dst_end   = {1'b0, dst_r} + {1'b0, len_r};
   assign range_bad = (src_end > LIMIT) || (dst_end > LIMIT);
   assign idx_nxt   = idx + ADDR_W'(1);
   assign m_clken   = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         src_r        <= '0;
         dst_r        <= '0;
         len_r        <= '0;
         idx          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         m_address    <= '0;
         m_byteenable <= '0;
         m_chipselect <= 1'b0;
         m_write      <= 1'b0;
         m_writedata  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  src_r <= src_addr;
                  dst_r <= dst_addr;
                  len_r <= len;
                  error <= 1'b0;
                  busy  <= 1'b1;
                  state <= CHECK;
               end
            end
            CHECK: begin
               idx <= '0;
               if (range_bad) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= FIN;
               end else if (len_r == '0) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  m_chipselect <= 1'b1;
                  m_byteenable <= '1;
                  m_address    <= src_r;
                  state        <= RD;
               end
            end
            RD: begin
               m_chipselect <= 1'b0;
               m_byteenable <= '0;
               state        <= LAT;
            end
            LAT: begin
               // m_writedata doubles as the captured-data register.
               m_writedata  <= m_readdata;
               m_chipselect <= 1'b1;
               m_write      <= 1'b1;
               m_byteenable <= '1;
               m_address    <= dst_r + idx;
               state        <= WR;
            end
            WR: begin
               idx     <= idx_nxt;
               m_write <= 1'b0;
               if (idx_nxt == len_r) begin
                  m_chipselect <= 1'b0;
                  m_byteenable <= '0;
                  done         <= 1'b1;
                  state        <= FIN;
               end else begin
                  m_address <= src_r + idx_nxt;
                  state     <= RD;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COPY_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         checksum <= '0;
      else if (state == IDLE && start)
         checksum <= '0;
      else if (state == LAT)
         checksum <= checksum + m_readdata;
   end
`else
   assign checksum = '0;
`endif

endmodule
